err_stats_collector: RTL and testbench

Multi-lane error-statistics engine for word-length optimisation runs. It compares up to NUM_LANES device-under-test output streams against one full-precision reference stream over a programmable window. Per lane it reports sum of squared error (SSE), maximum absolute error and a saturation flag. It sits between the DUT/reference filter instances and the UART control unit, and replaces the single-lane MSE collector with a start/busy/done handshake, a warm-up skip and multi-lane support.

---
 rtl/err_stats_pkg.sv | 17 +
 rtl/err_lane.sv | 72 +++++++
 rtl/err_stats_collector.sv | 114 +++++++++++
 tb/tb_err_stats_collector.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/err_stats_pkg.sv
// Shared types and width helpers for the multi-lane error-statistics engine.
package err_stats_pkg;

  typedef enum logic [2:0] {StIdle, StSkip, StAcc, StFlush, StDone} state_e;

  // Datapath stages between sample issue and accumulation.
  localparam int unsigned PIPE_LAT = 3;

  function automatic int unsigned diff_wl(input int unsigned data_wl);
    return data_wl + 1;
  endfunction

  function automatic int unsigned sq_wl(input int unsigned data_wl);
    return 2 * diff_wl(data_wl);
  endfunction

endpackage

// File: rtl/err_lane.sv
// One lane: difference, square/abs and saturating SSE / running-max accumulation.
module err_lane
  import err_stats_pkg::*;
#(
  parameter int unsigned DATA_WL = 16,
  parameter int unsigned ACC_WL  = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      issue,
  input  logic signed [DATA_WL-1:0] data_in,
  input  logic signed [DATA_WL-1:0] data_ref,
  output logic        [ACC_WL-1:0]  sse,
  output logic        [DATA_WL:0]   max_abs,
  output logic                      sat
);

  localparam int unsigned DIFF_WL = diff_wl(DATA_WL);
  localparam int unsigned SQ_WL   = sq_wl(DATA_WL);
  localparam int unsigned SUM_WL  = ((ACC_WL > SQ_WL) ? ACC_WL : SQ_WL) + 1;

  logic signed [DIFF_WL-1:0] diff_d, diff_q;
  logic        [DIFF_WL-1:0] abs_d, abs_q;
  logic        [SQ_WL-1:0]   sq_d, sq_q;
  logic        [SUM_WL-1:0]  sum;
  logic                      v1_q, v2_q, ovf;

  always_comb begin
    diff_d = {data_in[DATA_WL-1], data_in} - {data_ref[DATA_WL-1], data_ref};
    abs_d  = diff_q[DIFF_WL-1] ? $unsigned(-diff_q) : $unsigned(diff_q);
    sq_d   = SQ_WL'(abs_d) * SQ_WL'(abs_d);
    sum    = SUM_WL'(sse) + SUM_WL'(sq_q);
    // Any carry above the accumulator width means the true SSE no longer fits.
    ovf    = |sum[SUM_WL-1:ACC_WL];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      diff_q  <= '0;
      abs_q   <= '0;
      sq_q    <= '0;
      sse     <= '0;
      max_abs <= '0;
      sat     <= 1'b0;
    end else begin
      v1_q <= issue;
      v2_q <= v1_q;
      if (issue) diff_q <= diff_d;
      if (v1_q) begin
        sq_q  <= sq_d;
        abs_q <= abs_d;
      end
      if (clear) begin
        sse     <= '0;
        max_abs <= '0;
        sat     <= 1'b0;
      end else if (v2_q) begin
        if (ovf) begin
          sse <= '1;
          sat <= 1'b1;
        end else begin
          sse <= sum[ACC_WL-1:0];
        end
        if (abs_q > max_abs) max_abs <= abs_q;
      end
    end
  end

endmodule

// File: rtl/err_stats_collector.sv
// Multi-lane SSE / max-abs-error collector with start/busy/done handshake and warm-up skip.
module err_stats_collector
  import err_stats_pkg::*;
#(
  parameter int unsigned DATA_WL   = 16,
  parameter int unsigned NUM_LANES = 4,
  parameter int unsigned ACC_WL    = 64,
  parameter int unsigned CNT_WL    = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [CNT_WL-1:0]                n_samples,
  input  logic [CNT_WL-1:0]                skip,
  input  logic                             in_valid,
  input  logic [DATA_WL-1:0]               data_ref,
  input  logic [NUM_LANES*DATA_WL-1:0]     data_in,
  output logic                             busy,
  output logic                             done,
  output logic [NUM_LANES*ACC_WL-1:0]      sse,
  output logic [NUM_LANES*(DATA_WL+1)-1:0] max_abs,
  output logic [NUM_LANES-1:0]             sat
);

  localparam int unsigned DIFF_WL    = diff_wl(DATA_WL);
  localparam logic [1:0]  FLUSH_LAST = 2'(PIPE_LAT - 2);

  state_e            state_d, state_q;
  logic [CNT_WL-1:0] skip_d, skip_q, n_d, n_q, cnt_d, cnt_q;
  logic [1:0]        flush_d, flush_q;
  logic              issue, clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      skip_q  <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    flush_d = flush_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          skip_d = skip;
          n_d    = n_samples;
          cnt_d  = '0;
          if (skip != '0)           state_d = StSkip;
          else if (n_samples != '0) state_d = StAcc;
          else                      state_d = StDone;
        end
      end
      StSkip: begin
        if (in_valid) begin
          skip_d = skip_q - CNT_WL'(1);
          if (skip_q == CNT_WL'(1)) state_d = (n_q != '0) ? StAcc : StDone;
        end
      end
      StAcc: begin
        if (in_valid) begin
          cnt_d = cnt_q + CNT_WL'(1);
          if (cnt_d == n_q) begin
            state_d = StFlush;
            flush_d = '0;
          end
        end
      end
      StFlush: begin
        if (flush_q == FLUSH_LAST) state_d = StDone;
        else                       flush_d = flush_q + 2'd1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q == StSkip) || (state_q == StAcc) || (state_q == StFlush);
    done  = (state_q == StDone);
    issue = (state_q == StAcc) && in_valid;
    clear = (state_q == StIdle) && start;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    err_lane #(
      .DATA_WL(DATA_WL),
      .ACC_WL (ACC_WL)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .issue   (issue),
      .data_in (data_in[i*DATA_WL +: DATA_WL]),
      .data_ref(data_ref),
      .sse     (sse[i*ACC_WL +: ACC_WL]),
      .max_abs (max_abs[i*DIFF_WL +: DIFF_WL]),
      .sat     (sat[i])
    );
  end

endmodule

// File: tb/tb_err_stats_collector.sv
// Bench for err_stats_collector: vector table of runs, expected results queued and checked on done.
module tb_err_stats_collector;

  localparam int DW  = 16;
  localparam int NL  = 4;
  localparam int AW  = 64;
  localparam int AWS = 20;
  localparam int CW  = 32;
  localparam int MW  = DW + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic [CW-1:0] n_samples = '0;
  logic [CW-1:0] skip = '0;
  logic [DW-1:0] data_ref = '0;
  logic [NL*DW-1:0] data_in = '0;

  logic busy, done, busy_s, done_s;
  logic [NL*AW-1:0] sse;
  logic [NL*AWS-1:0] sse_s;
  logic [NL*MW-1:0] max_abs, max_abs_s;
  logic [NL-1:0] sat, sat_s;

  err_stats_collector #(.DATA_WL(DW), .NUM_LANES(NL), .ACC_WL(AW), .CNT_WL(CW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .skip(skip),
    .in_valid(in_valid), .data_ref(data_ref), .data_in(data_in), .busy(busy), .done(done),
    .sse(sse), .max_abs(max_abs), .sat(sat)
  );

  // Narrow-accumulator copy fed the same stimulus, used for saturation behaviour.
  err_stats_collector #(.DATA_WL(DW), .NUM_LANES(NL), .ACC_WL(AWS), .CNT_WL(CW)) u_dut_s (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples), .skip(skip),
    .in_valid(in_valid), .data_ref(data_ref), .data_in(data_in), .busy(busy_s), .done(done_s),
    .sse(sse_s), .max_abs(max_abs_s), .sat(sat_s)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int skip; int n; int lead; int l0; int refv; int d;
    bit bubbles; bit poke;
    longint unsigned e_sse; longint unsigned e_max; longint unsigned e_sse_s; bit e_sat_s;
  } vec_t;

  typedef struct {
    int idx; int done_cyc;
    longint unsigned sse[NL]; longint unsigned mx[NL];
    longint unsigned sse_s; bit sat_s;
  } exp_t;

  vec_t vecs[8];
  exp_t exp_q[$];
  exp_t got;
  int checks = 0;
  int errors = 0;
  int done_count = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int k, input int val);
    data_in[k*DW +: DW] = val[DW-1:0];
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      done_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d: got done=1, required done=0", cyc);
      end else begin
        got = exp_q.pop_front();
        chk($sformatf("v%0d_done_cycle", got.idx), longint'(cyc), longint'(got.done_cyc));
        chk($sformatf("v%0d_busy_at_done", got.idx), busy, 0);
        chk($sformatf("v%0d_done_small", got.idx), done_s, 1);
        for (int k = 0; k < NL; k++) begin
          chk($sformatf("v%0d_sse%0d", got.idx, k), sse[k*AW +: AW], got.sse[k]);
          chk($sformatf("v%0d_max%0d", got.idx, k), max_abs[k*MW +: MW], got.mx[k]);
        end
        chk($sformatf("v%0d_sat", got.idx), sat, 0);
        chk($sformatf("v%0d_sse_small", got.idx), sse_s[AWS-1:0], got.sse_s);
        chk($sformatf("v%0d_sat_small", got.idx), sat_s[0], got.sat_s);
      end
    end
  end

  task automatic run(input int i);
    vec_t v;
    exp_t e;
    int last, dc0, k, dk;
    v = vecs[i];
    dc0 = done_count;
    n_samples = v.n[CW-1:0];
    skip = v.skip[CW-1:0];
    in_valid = 1'b0;
    start = 1'b1;
    last = cyc;
    tick();
    start = 1'b0;
    if (!(v.skip == 0 && v.n == 0)) chk($sformatf("v%0d_busy_after_start", i), busy, 1);
    for (int s = 0; s < v.skip + v.n; s++) begin
      data_ref = v.refv[DW-1:0];
      if (s < v.skip) begin
        set_lane(0, v.lead);
        for (int l = 1; l < NL; l++) set_lane(l, v.refv - 777);
      end else begin
        set_lane(0, v.l0);
        for (int l = 1; l < NL; l++) set_lane(l, v.refv + l * v.d);
      end
      in_valid = 1'b1;
      if (v.poke && s == v.skip + 1) begin
        chk($sformatf("v%0d_busy_at_poke", i), busy, 1);
        start = 1'b1;
        n_samples = 1;
        skip = 0;
      end
      last = cyc;
      tick();
      start = 1'b0;
      if (v.bubbles) begin
        in_valid = 1'b0;
        set_lane(0, 12345);
        tick();
      end
    end
    e.idx = i;
    e.done_cyc = last + ((v.n > 0) ? 3 : 1);
    e.sse[0] = v.e_sse;
    e.mx[0] = v.e_max;
    for (int l = 1; l < NL; l++) begin
      dk = l * v.d;
      e.sse[l] = longint'(v.n) * longint'(dk * dk);
      e.mx[l] = (dk < 0) ? longint'(-dk) : longint'(dk);
    end
    e.sse_s = v.e_sse_s;
    e.sat_s = v.e_sat_s;
    exp_q.push_back(e);
    // Valid junk after the last sample must never reach the accumulators.
    in_valid = 1'b1;
    set_lane(0, 31111);
    k = 0;
    while (done_count == dc0 && k < 40) begin
      tick();
      k++;
    end
    if (done_count == dc0) begin
      checks++;
      errors++;
      $display("FAIL v%0d_done_timeout: got no done in 40 cycles, required one", i);
      void'(exp_q.pop_front());
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{2, 4, 1000, 103, 100, 1, 1'b0, 1'b0, 64'd36, 64'd3, 64'd36, 1'b0};
    vecs[1] = '{2, 4, 1000, 103, 100, 1, 1'b1, 1'b0, 64'd36, 64'd3, 64'd36, 1'b0};
    vecs[2] = '{0, 1, 0, -32768, 32767, 0, 1'b0, 1'b0, 64'd4294836225, 64'd65535,
                64'd1048575, 1'b1};
    vecs[3] = '{1, 3, -20000, -5, 7, -2, 1'b0, 1'b0, 64'd432, 64'd12, 64'd432, 1'b0};
    vecs[4] = '{0, 2, 0, 1100, 100, 0, 1'b0, 1'b0, 64'd2000000, 64'd1000, 64'd1048575, 1'b1};
    vecs[5] = '{3, 0, 500, 0, 0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0};
    vecs[6] = '{0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 64'd0, 64'd0, 64'd0, 1'b0};
    vecs[7] = '{0, 3, 0, 110, 100, 3, 1'b0, 1'b1, 64'd300, 64'd10, 64'd300, 1'b0};

    #3;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_sse", sse, 0);
    chk("reset_max_abs", max_abs, 0);
    chk("reset_sat", sat, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      run(i);
      if (i == 0) begin
        tick();
        tick();
        chk("hold_sse0_in_idle", sse[AW-1:0], 36);
        chk("hold_max0_in_idle", max_abs[MW-1:0], 3);
      end
    end

    // Reset in the middle of an accumulation aborts the run silently.
    n_samples = 10;
    skip = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    data_ref = 16'd100;
    for (int l = 0; l < NL; l++) set_lane(l, 100);
    set_lane(0, 200);
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++) tick();
    chk("midrun_sse0_before_reset", sse[AW-1:0], 10000);
    chk("midrun_busy_before_reset", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrun_reset_busy", busy, 0);
    chk("midrun_reset_done", done, 0);
    chk("midrun_reset_sse", sse, 0);
    chk("midrun_reset_max_abs", max_abs, 0);
    chk("midrun_reset_sat", sat_s | sat, 0);
    tick();
    rst = 1'b0;
    begin
      int dc0;
      dc0 = done_count;
      for (int s = 0; s < 12; s++) tick();
      chk("midrun_no_done_after_reset", done_count, dc0);
      chk("midrun_idle_after_reset", busy, 0);
    end
    in_valid = 1'b0;
    tick();

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
